// File: rtl/mul_hilo_ctrl.sv
// mul_hilo_ctrl: sequences multiply and HI/LO-move requests onto a fixed-latency multiplier
// and commits its 64-bit product into the architectural HI/LO registers.
// Define MUL_HILO_ACC_EN to build the MADD/MADDU accumulate path (ACC state, prod, adder).
module mul_hilo_ctrl #(
  parameter int unsigned LAT = 3
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  input  logic        flush,
  output logic [32:0] mul_src1,
  output logic [32:0] mul_src2,
  output logic        mul_start,
  input  logic [63:0] mul_result,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        done
);

  localparam logic [2:0] OpMult  = 3'b000;
  localparam logic [2:0] OpMultu = 3'b001;
  localparam logic [2:0] OpMthi  = 3'b010;
  localparam logic [2:0] OpMtlo  = 3'b011;
`ifdef MUL_HILO_ACC_EN
  localparam logic [2:0] OpMadd  = 3'b100;
  localparam logic [2:0] OpMaddu = 3'b101;
`endif

  // WAIT lasts LAT cycles: loaded with LAT-1, commit happens in the cycle it reads zero.
  localparam logic [3:0] CntLoad = 4'(LAT - 1);

`ifdef MUL_HILO_ACC_EN
  typedef enum logic [1:0] {StIdle, StWait, StAcc} state_e;
`else
  typedef enum logic [1:0] {StIdle, StWait} state_e;
`endif

  state_e      state_q, state_d;
  logic [3:0]  cnt_q;
  logic [31:0] hi_q, lo_q;
  logic        acc;
  logic        is_mul;
  logic        is_acc_op;
  logic        commit_mul;
  logic        commit_acc;

`ifdef MUL_HILO_ACC_EN
  logic        acc_op_q;
  logic [63:0] prod_q;
`endif

  // Request decode: which codes launch the multiplier, and which accumulate.
  always_comb begin
`ifdef MUL_HILO_ACC_EN
    is_acc_op = (req_op == OpMadd) || (req_op == OpMaddu);
`else
    is_acc_op = 1'b0;
`endif
    is_mul = (req_op == OpMult) || (req_op == OpMultu) || is_acc_op;
  end

  // Operand extension: even opcodes among the multiplies (MULT/MADD) are signed.
  always_comb begin
    mul_src1 = {~req_op[0] & req_a[31], req_a};
    mul_src2 = {~req_op[0] & req_b[31], req_b};
  end

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= StIdle;
    else         state_q <= state_d;
  end

  // Next-state logic; flush always returns to IDLE from a busy state.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (acc && is_mul) state_d = StWait;
      StWait: begin
        if (flush) begin
          state_d = StIdle;
        end else if (cnt_q == 4'd0) begin
`ifdef MUL_HILO_ACC_EN
          state_d = acc_op_q ? StAcc : StIdle;
`else
          state_d = StIdle;
`endif
        end
      end
`ifdef MUL_HILO_ACC_EN
      StAcc:  state_d = StIdle;
`endif
      default: state_d = StIdle;
    endcase
  end

  // Handshake, launch strobe and commit qualifiers; flush suppresses every commit.
  always_comb begin
    req_ready  = (state_q == StIdle);
    busy       = (state_q != StIdle);
    acc        = req_valid & req_ready & ~flush;
    mul_start  = acc & is_mul;
`ifdef MUL_HILO_ACC_EN
    commit_mul = (state_q == StWait) && (cnt_q == 4'd0) && !flush && !acc_op_q;
    commit_acc = (state_q == StAcc) && !flush;
`else
    commit_mul = (state_q == StWait) && (cnt_q == 4'd0) && !flush;
    commit_acc = 1'b0;
`endif
    done       = commit_mul | commit_acc;
  end

  // Latency counter: cleared on flush so a cancelled op leaves no residue.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q <= 4'd0;
    end else if (acc && is_mul) begin
      cnt_q <= CntLoad;
    end else if (state_q == StWait) begin
      if (flush)               cnt_q <= 4'd0;
      else if (cnt_q != 4'd0)  cnt_q <= cnt_q - 4'd1;
    end
  end

`ifdef MUL_HILO_ACC_EN
  // Accumulate path: remember the op class and hold the product for the ACC add.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      acc_op_q <= 1'b0;
      prod_q   <= 64'd0;
    end else begin
      if (acc && is_mul) acc_op_q <= is_acc_op;
      if ((state_q == StWait) && (cnt_q == 4'd0) && !flush && acc_op_q) prod_q <= mul_result;
    end
  end
`endif

  // Architectural HI/LO: product commit, accumulate, or direct move.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hi_q <= 32'd0;
      lo_q <= 32'd0;
    end else if (commit_mul) begin
      {hi_q, lo_q} <= mul_result;
`ifdef MUL_HILO_ACC_EN
    end else if (commit_acc) begin
      {hi_q, lo_q} <= {hi_q, lo_q} + prod_q;
`endif
    end else if (acc && (req_op == OpMthi)) begin
      hi_q <= req_a;
    end else if (acc && (req_op == OpMtlo)) begin
      lo_q <= req_a;
    end
  end

  assign hi = hi_q;
  assign lo = lo_q;

endmodule

// File: tb/tb_mul_hilo_ctrl.sv
// Self-checking bench for mul_hilo_ctrl with a behavioural LAT-cycle multiplier model.
// Build with MUL_HILO_ACC_EN defined to exercise the accumulate path.
module tb_mul_hilo_ctrl;

  localparam int unsigned LAT = 3;
`ifdef MUL_HILO_ACC_EN
  localparam bit AccEn = 1'b1;
`else
  localparam bit AccEn = 1'b0;
`endif

  logic        clk, resetn;
  logic        req_valid, req_ready, flush, mul_start, busy, done;
  logic [2:0]  req_op;
  logic [31:0] req_a, req_b, hi, lo;
  logic [32:0] mul_src1, mul_src2;
  logic [63:0] mul_result;

  int checks = 0;
  int errors = 0;
  logic [31:0] m_hi, m_lo;

  mul_hilo_ctrl #(.LAT(LAT)) dut (
    .clk(clk), .resetn(resetn), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b), .flush(flush),
    .mul_src1(mul_src1), .mul_src2(mul_src2), .mul_start(mul_start),
    .mul_result(mul_result), .hi(hi), .lo(lo), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Multiplier model: product of the launched operands, valid exactly LAT cycles later,
  // random garbage at every other time.
  logic [63:0] pipe_d [LAT];
  logic        pipe_v [LAT];
  logic [63:0] garbage;
  logic signed [65:0] launch_prod;
  assign launch_prod = $signed(mul_src1) * $signed(mul_src2);
  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < LAT; i++) pipe_v[i] <= 1'b0;
    end else begin
      pipe_v[0] <= mul_start;
      pipe_d[0] <= launch_prod[63:0];
      for (int i = 1; i < LAT; i++) begin
        pipe_v[i] <= pipe_v[i-1];
        pipe_d[i] <= pipe_d[i-1];
      end
    end
    garbage <= {$urandom, $urandom};
  end
  assign mul_result = pipe_v[LAT-1] ? pipe_d[LAT-1] : garbage;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Reference arithmetic straight from the op semantics.
  function automatic logic [63:0] ref_prod(input logic [2:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
    longint sa, sb;
    logic [63:0] ua, ub;
    if (op == 3'b000 || op == 3'b100) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      return 64'(sa * sb);
    end
    ua = {32'd0, a};
    ub = {32'd0, b};
    return ua * ub;
  endfunction

  function automatic bit ref_is_mul(input logic [2:0] op);
    return (op == 3'b000) || (op == 3'b001) || (AccEn && (op == 3'b100 || op == 3'b101));
  endfunction

  function automatic bit ref_is_acc(input logic [2:0] op);
    return AccEn && (op == 3'b100 || op == 3'b101);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req_valid = 1'b0; req_op = 3'b111; req_a = '0; req_b = '0; flush = 1'b0;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    idle_inputs();
    #12;
    checks++; if (hi !== 32'd0) begin errors++; $display("FAIL reset_hi got %h exp 0", hi); end
    checks++; if (lo !== 32'd0) begin errors++; $display("FAIL reset_lo got %h exp 0", lo); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", req_ready); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", done); end
    checks++; if (mul_start !== 1'b0) begin errors++; $display("FAIL reset_start got %b exp 0", mul_start); end
    #1 resetn = 1'b1;
    m_hi = 32'd0; m_lo = 32'd0;
    step();
  endtask

  task automatic test_mult_signed();
    req_valid = 1'b1; req_op = 3'b000; req_a = 32'hFFFFFFFF; req_b = 32'd2;
    #1;
    checks++; if (mul_start !== 1'b1) begin errors++; $display("FAIL mult_start got %b exp 1", mul_start); end
    checks++; if (mul_src1 !== 33'h1FFFFFFFF) begin errors++; $display("FAIL mult_src1 got %h exp 1ffffffff", mul_src1); end
    checks++; if (mul_src2 !== 33'h000000002) begin errors++; $display("FAIL mult_src2 got %h exp 000000002", mul_src2); end
    step();
    idle_inputs();
    for (int k = 1; k <= LAT; k++) begin
      #1;
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mult_busy k=%0d got %b exp 1", k, busy); end
      checks++; if (done !== (k == LAT)) begin errors++; $display("FAIL mult_done k=%0d got %b exp %b", k, done, k == LAT); end
      step();
    end
    m_hi = 32'hFFFFFFFF; m_lo = 32'hFFFFFFFE;
    checks++; if (hi !== m_hi) begin errors++; $display("FAIL mult_hi got %h exp %h", hi, m_hi); end
    checks++; if (lo !== m_lo) begin errors++; $display("FAIL mult_lo got %h exp %h", lo, m_lo); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mult_busy_end got %b exp 0", busy); end
  endtask

  task automatic test_multu_held();
    req_valid = 1'b1; req_op = 3'b001; req_a = 32'hFFFFFFFF; req_b = 32'hFFFFFFFF;
    #1;
    checks++; if (mul_src1 !== 33'h0FFFFFFFF) begin errors++; $display("FAIL multu_src1 got %h exp 0ffffffff", mul_src1); end
    step();
    req_op = 3'b000; req_a = 32'd5; req_b = 32'd6;
    for (int k = 1; k <= LAT; k++) begin
      #1;
      checks++; if (req_ready !== 1'b0 || mul_start !== 1'b0) begin
        errors++; $display("FAIL held_blocked k=%0d got ready=%b start=%b exp 0 0", k, req_ready, mul_start);
      end
      step();
    end
    #1;
    m_hi = 32'hFFFFFFFE; m_lo = 32'h00000001;
    checks++; if (hi !== m_hi || lo !== m_lo) begin errors++; $display("FAIL multu_hilo got %h_%h exp %h_%h", hi, lo, m_hi, m_lo); end
    checks++; if (req_ready !== 1'b1 || mul_start !== 1'b1) begin
      errors++; $display("FAIL held_accept got ready=%b start=%b exp 1 1", req_ready, mul_start);
    end
    step();
    idle_inputs();
    for (int k = 1; k <= LAT; k++) step();
    m_hi = 32'd0; m_lo = 32'd30;
    checks++; if (hi !== m_hi || lo !== m_lo) begin errors++; $display("FAIL held_hilo got %h_%h exp %h_%h", hi, lo, m_hi, m_lo); end
  endtask

  task automatic test_mt_back_to_back();
    req_valid = 1'b1; req_op = 3'b010; req_a = 32'h12345678;
    #1;
    checks++; if (mul_start !== 1'b0) begin errors++; $display("FAIL mthi_start got %b exp 0", mul_start); end
    step();
    m_hi = 32'h12345678;
    checks++; if (hi !== m_hi) begin errors++; $display("FAIL mthi_hi got %h exp %h", hi, m_hi); end
    checks++; if (busy !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL mthi_busy got busy=%b ready=%b exp 0 1", busy, req_ready); end
    req_op = 3'b011; req_a = 32'h9ABCDEF0;
    step();
    idle_inputs();
    m_lo = 32'h9ABCDEF0;
    checks++; if (lo !== m_lo || hi !== m_hi) begin errors++; $display("FAIL mtlo_hilo got %h_%h exp %h_%h", hi, lo, m_hi, m_lo); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mtlo_busy got %b exp 0", busy); end
  endtask

  task automatic test_flush();
    req_valid = 1'b1; req_op = 3'b000; req_a = 32'd3; req_b = 32'd4;
    step();
    idle_inputs();
    step();
    flush = 1'b1;
    #1;
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL flush_done got %b exp 0", done); end
    step();
    flush = 1'b0;
    for (int k = 0; k < LAT; k++) begin
      #1;
      checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL flush_after k=%0d got busy=%b done=%b exp 0 0", k, busy, done); end
      checks++; if (hi !== m_hi || lo !== m_lo) begin errors++; $display("FAIL flush_hilo got %h_%h exp %h_%h", hi, lo, m_hi, m_lo); end
      step();
    end
    req_valid = 1'b1; req_op = 3'b000; req_a = 32'd7; req_b = 32'd9; flush = 1'b1;
    #1;
    checks++; if (mul_start !== 1'b0) begin errors++; $display("FAIL flush_accept_start got %b exp 0", mul_start); end
    step();
    idle_inputs();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flush_accept_busy got %b exp 0", busy); end
  endtask

  task automatic test_accumulate();
    req_valid = 1'b1; req_op = 3'b010; req_a = 32'h00000000; step();
    req_op = 3'b011; req_a = 32'hFFFFFFFF; step();
    m_hi = 32'h00000000; m_lo = 32'hFFFFFFFF;
    req_op = 3'b101; req_a = 32'd1; req_b = 32'd1;
    #1;
    checks++; if (mul_start !== AccEn) begin errors++; $display("FAIL maddu_start got %b exp %b", mul_start, AccEn); end
    step();
    idle_inputs();
    if (AccEn) begin
      for (int k = 1; k <= LAT + 1; k++) begin
        #1;
        checks++; if (busy !== 1'b1 || done !== (k == LAT + 1)) begin
          errors++; $display("FAIL maddu_timing k=%0d got busy=%b done=%b exp 1 %b", k, busy, done, k == LAT + 1);
        end
        step();
      end
      m_hi = 32'h00000001; m_lo = 32'h00000000;
    end else begin
      #1;
      checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL maddu_noop got busy=%b done=%b exp 0 0", busy, done); end
      step();
    end
    checks++; if (hi !== m_hi || lo !== m_lo) begin errors++; $display("FAIL maddu_hilo got %h_%h exp %h_%h", hi, lo, m_hi, m_lo); end
  endtask

  task automatic test_random();
    logic [2:0]  op;
    logic [31:0] a, b;
    logic [63:0] p, sum;
    bit          fl_acc, ok;
    int          lat, fl_at;
    for (int n = 0; n < 60; n++) begin
      op = 3'($urandom_range(0, 7));
      a = $urandom; b = $urandom;
      if ($urandom_range(0, 3) == 0) a = 32'hFFFFFFFF;
      fl_acc = ($urandom_range(0, 7) == 0);
      req_valid = 1'b1; req_op = op; req_a = a; req_b = b; flush = fl_acc;
      #1;
      checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rnd_ready n=%0d got %b exp 1", n, req_ready); end
      checks++; if (mul_start !== (!fl_acc && ref_is_mul(op))) begin
        errors++; $display("FAIL rnd_start n=%0d op=%0d got %b exp %b", n, op, mul_start, !fl_acc && ref_is_mul(op));
      end
      if (!fl_acc && ref_is_mul(op)) begin
        checks++;
        if (mul_src1 !== (op[0] ? {1'b0, a} : {a[31], a}) || mul_src2 !== (op[0] ? {1'b0, b} : {b[31], b})) begin
          errors++; $display("FAIL rnd_src n=%0d got %h %h a=%h b=%h op=%0d", n, mul_src1, mul_src2, a, b, op);
        end
      end
      step();
      idle_inputs();
      if (!fl_acc && ref_is_mul(op)) begin
        lat = ref_is_acc(op) ? LAT + 1 : LAT;
        fl_at = ($urandom_range(0, 3) == 0) ? $urandom_range(1, lat) : 0;
        for (int k = 1; k <= lat; k++) begin
          flush = (k == fl_at);
          #1;
          checks++; if (busy !== 1'b1 || done !== (k == lat && fl_at == 0)) begin
            errors++; $display("FAIL rnd_seq n=%0d k=%0d got busy=%b done=%b exp 1 %b", n, k, busy, done, k == lat && fl_at == 0);
          end
          step();
          if (k == fl_at) break;
        end
        flush = 1'b0;
        if (fl_at == 0) begin
          p = ref_prod(op, a, b);
          sum = ref_is_acc(op) ? ({m_hi, m_lo} + p) : p;
          {m_hi, m_lo} = sum;
        end
      end else if (!fl_acc && op == 3'b010) begin
        m_hi = a;
      end else if (!fl_acc && op == 3'b011) begin
        m_lo = a;
      end
      ok = (hi === m_hi) && (lo === m_lo) && (busy === 1'b0);
      checks++; if (!ok) begin
        errors++; $display("FAIL rnd_result n=%0d op=%0d got %h_%h busy=%b exp %h_%h 0", n, op, hi, lo, busy, m_hi, m_lo);
      end
    end
  endtask

  task automatic test_reset_mid_op();
    req_valid = 1'b1; req_op = 3'b010; req_a = 32'h1; step();
    req_op = 3'b011; req_a = 32'h2; step();
    req_op = 3'b001; req_a = 32'h55; req_b = 32'h77; step();
    idle_inputs();
    #2 resetn = 1'b0;
    #1;
    checks++; if (hi !== 32'd0 || lo !== 32'd0) begin errors++; $display("FAIL rstmid_hilo got %h_%h exp 0_0", hi, lo); end
    checks++; if (busy !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL rstmid_state got busy=%b ready=%b exp 0 1", busy, req_ready); end
    #2 resetn = 1'b1;
    m_hi = 32'd0; m_lo = 32'd0;
    for (int k = 0; k < LAT + 2; k++) begin
      step();
      checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rstmid_after k=%0d got done=%b busy=%b exp 0 0", k, done, busy); end
    end
    checks++; if (hi !== m_hi || lo !== m_lo) begin errors++; $display("FAIL rstmid_final got %h_%h exp 0_0", hi, lo); end
  endtask

  initial begin
    test_reset();
    test_mult_signed();
    test_multu_held();
    test_mt_back_to_back();
    test_flush();
    test_accumulate();
    test_random();
    test_reset_mid_op();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
